// File: rtl/memctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package memctrl_pkg;

  // Controller states
  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_READ  = 2'd1,
    MC_WRITE = 2'd2
  } mc_state_t;

  // LSB op encoding: bit3 = store, bit2 = zero-extend, bits[1:0] = size code
  localparam logic [3:0] OP_LB  = 4'h0;
  localparam logic [3:0] OP_LH  = 4'h1;
  localparam logic [3:0] OP_LW  = 4'h2;
  localparam logic [3:0] OP_LBU = 4'h4;
  localparam logic [3:0] OP_LHU = 4'h5;
  localparam logic [3:0] OP_SB  = 4'h8;
  localparam logic [3:0] OP_SH  = 4'h9;
  localparam logic [3:0] OP_SW  = 4'hA;

  // Number of bus bytes for a size code (1, 2 or 4)
  function automatic logic [2:0] op_size(input logic [1:0] sz_code);
    case (sz_code)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/memctrl_ext.sv
// Size/sign extension of the reassembled read buffer, shared by load and fetch.
// Latency: combinational.
// Backpressure: none; output is a pure function of the buffer and the op.
module memctrl_ext
  import memctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  // Select the extension rule for the latched op; fetch is presented as LW
  always_comb begin
    ext = raw;
    case (op)
      OP_LB:   ext = {{24{raw[7]}}, raw[7:0]};
      OP_LH:   ext = {{16{raw[15]}}, raw[15:0]};
      OP_LBU:  ext = {24'h0, raw[7:0]};
      OP_LHU:  ext = {16'h0, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/memctrl.sv
// Byte-serial memory controller for LSB loads/stores and instruction fetch; MEMCTRL_IO_STALL_EN enables UART-full write stall.
// Latency: reads n+1 cycles from acceptance, writes n cycles (n = 1/2/4 bytes).
// Backpressure: rdy_in low freezes everything; with MEMCTRL_IO_STALL_EN an IO write byte waits on io_buffer_full.
module memctrl
  import memctrl_pkg::*;
#(
  parameter logic [1:0] IO_BASE_HI = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        re,
  input  logic        we,
  input  logic [3:0]  ls_type,
  input  logic [31:0] addr,
  input  logic [31:0] store_val,
  output logic        ls_finished,
  output logic [31:0] read_val,
  input  logic        if_re,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_inst,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  mc_state_t   state_q;
  logic [2:0]  cnt_q;
  logic [2:0]  size_q;
  logic [3:0]  op_q;
  logic        fetch_q;
  logic [31:0] wdat_q;
  logic [31:0] buf_q;
  logic [31:0] mem_a_q;
  logic [7:0]  mem_dout_q;
  logic        mem_wr_q;
  logic        ls_finished_q;
  logic        if_done_q;
  logic [7:0]  hold_q;
  logic        hold_vld_q;
  logic        io_hold;
  logic [7:0]  rd_byte;
  logic [1:0]  byte_idx;
  logic [31:0] ext_val;

`ifdef MEMCTRL_IO_STALL_EN
  assign io_hold = (state_q == MC_WRITE) && (mem_a_q[17:16] == IO_BASE_HI) && io_buffer_full;
`else
  assign io_hold = io_buffer_full & 1'b0;
`endif

  // A freeze leaves mem_a pointing one byte ahead, so the byte that was in
  // flight when rdy_in dropped is parked and consumed on the resume edge.
  assign rd_byte  = hold_vld_q ? hold_q : mem_din;
  assign byte_idx = cnt_q[1:0] - 2'd1;

  assign mem_a       = mem_a_q;
  assign mem_dout    = mem_dout_q;
  assign mem_wr      = mem_wr_q & rdy_in & ~io_hold;
  assign ls_finished = ls_finished_q;
  assign if_done     = if_done_q;
  assign read_val    = ext_val;
  assign if_inst     = ext_val;

  memctrl_ext u_ext (
    .op  (op_q),
    .raw (buf_q),
    .ext (ext_val)
  );

  // Request acceptance, byte sequencing, read reassembly and done pulses
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= MC_IDLE;
      cnt_q         <= 3'd0;
      size_q        <= 3'd0;
      op_q          <= 4'd0;
      fetch_q       <= 1'b0;
      wdat_q        <= 32'd0;
      buf_q         <= 32'd0;
      mem_a_q       <= 32'd0;
      mem_dout_q    <= 8'd0;
      mem_wr_q      <= 1'b0;
      ls_finished_q <= 1'b0;
      if_done_q     <= 1'b0;
      hold_q        <= 8'd0;
      hold_vld_q    <= 1'b0;
    end else if (!rdy_in) begin
      if (state_q == MC_READ && !hold_vld_q) begin
        hold_q     <= mem_din;
        hold_vld_q <= 1'b1;
      end
    end else begin
      ls_finished_q <= 1'b0;
      if_done_q     <= 1'b0;
      hold_vld_q    <= 1'b0;
      case (state_q)
        MC_IDLE: begin
          cnt_q <= 3'd0;
          if (!clear && !ls_finished_q && !if_done_q) begin
            if (re || we) begin
              op_q    <= ls_type;
              size_q  <= op_size(ls_type[1:0]);
              fetch_q <= 1'b0;
              mem_a_q <= addr;
              buf_q   <= 32'd0;
              if (we) begin
                state_q    <= MC_WRITE;
                mem_wr_q   <= 1'b1;
                mem_dout_q <= store_val[7:0];
                wdat_q     <= store_val;
              end else begin
                state_q <= MC_READ;
              end
            end else if (if_re) begin
              op_q    <= OP_LW;
              size_q  <= 3'd4;
              fetch_q <= 1'b1;
              mem_a_q <= if_addr;
              buf_q   <= 32'd0;
              state_q <= MC_READ;
            end
          end
        end
        MC_READ: begin
          if (clear) begin
            state_q <= MC_IDLE;
            cnt_q   <= 3'd0;
          end else begin
            if (cnt_q != 3'd0) buf_q[{byte_idx, 3'b000} +: 8] <= rd_byte;
            if (cnt_q == size_q) begin
              state_q <= MC_IDLE;
              cnt_q   <= 3'd0;
              if (fetch_q) if_done_q <= 1'b1;
              else         ls_finished_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q + 3'd1 < size_q) mem_a_q <= mem_a_q + 32'd1;
            end
          end
        end
        MC_WRITE: begin
          if (!io_hold) begin
            if (cnt_q + 3'd1 == size_q) begin
              state_q       <= MC_IDLE;
              cnt_q         <= 3'd0;
              mem_wr_q      <= 1'b0;
              ls_finished_q <= 1'b1;
            end else begin
              cnt_q      <= cnt_q + 3'd1;
              mem_a_q    <= mem_a_q + 32'd1;
              mem_dout_q <= wdat_q[15:8];
              wdat_q     <= wdat_q >> 8;
            end
          end
        end
        default: state_q <= MC_IDLE;
      endcase
    end
  end

endmodule
